// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the serial pattern pulse generator.
package pulse_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The bit counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int bit_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/pulse_prescaler.sv
// Clock-enable prescaler: pulses tick once every (latched divisor + 1) enabled clocks.
module pulse_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] div_q;

    assign tick = enable && (count == div_q);

    // A clear while disabled arms a new run and captures the divisor; a clear
    // while enabled only restarts the count so a running step period survives.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            div_q <= '0;
        end else if (clear) begin
            count <= '0;
            if (!enable) begin
                div_q <= divisor;
            end
        end else if (enable) begin
            if (tick) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_pulse_generator.sv
// Serial pattern pulse generator: emits a WIDTH-bit pattern one bit per prescaler tick.
// Optional macro PATTERN_PULSE_DIR_EN adds a dir input for LSB-first emission.
module pattern_pulse_generator #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_flag,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic             start,
    input  logic             stop,
    input  logic             one_shot,
    input  logic [DIV_W-1:0] divisor,
`ifdef PATTERN_PULSE_DIR_EN
    input  logic             dir,
`endif
    output logic             o,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pattern_q
);

    import pulse_gen_pkg::*;

    localparam int CNT_W = bit_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);

    state_t           state_q, state_n;
    logic [WIDTH-1:0] pattern_n;
    logic [WIDTH-1:0] rotated;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_n;
    logic             o_n, done_n;
    logic             one_shot_q, one_shot_n;
    logic             emit_bit;
    logic             tick;
    logic             presc_clear;
    logic             presc_enable;
`ifdef PATTERN_PULSE_DIR_EN
    logic             dir_q, dir_n;
`endif

    assign busy         = (state_q == RUN);
    assign presc_enable = (state_q == RUN);
    assign presc_clear  = ((state_q == IDLE) && start) || ((state_q == RUN) && load_flag);

    pulse_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (presc_clear),
        .enable (presc_enable),
        .divisor(divisor),
        .tick   (tick)
    );

    always_comb begin
        emit_bit = pattern_q[WIDTH-1];
        rotated  = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
`ifdef PATTERN_PULSE_DIR_EN
        if (dir_q) begin
            emit_bit = pattern_q[0];
            rotated  = {pattern_q[0], pattern_q[WIDTH-1:1]};
        end
`endif
    end

    // Priority: load, then stop, then start, then the step tick.
    always_comb begin
        state_n    = state_q;
        pattern_n  = pattern_q;
        bit_cnt_n  = bit_cnt_q;
        o_n        = o;
        done_n     = 1'b0;
        one_shot_n = one_shot_q;
`ifdef PATTERN_PULSE_DIR_EN
        dir_n      = dir_q;
`endif

        if (load_flag) begin
            pattern_n = pattern_in;
            if (state_q == RUN) begin
                bit_cnt_n = '0;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n    = RUN;
                    one_shot_n = one_shot;
                    bit_cnt_n  = '0;
`ifdef PATTERN_PULSE_DIR_EN
                    dir_n      = dir;
`endif
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    o_n     = 1'b0;
                end else if (!load_flag && tick) begin
                    if ((bit_cnt_q == LAST_BIT) && one_shot_q) begin
                        state_n = IDLE;
                        o_n     = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        // Continuous mode wraps straight into the next pass with no idle step.
                        o_n       = emit_bit;
                        pattern_n = rotated;
                        bit_cnt_n = (bit_cnt_q == LAST_BIT) ? CNT_W'(1) : bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pattern_q  <= '0;
            bit_cnt_q  <= '0;
            o          <= 1'b0;
            done       <= 1'b0;
            one_shot_q <= 1'b0;
`ifdef PATTERN_PULSE_DIR_EN
            dir_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_n;
            pattern_q  <= pattern_n;
            bit_cnt_q  <= bit_cnt_n;
            o          <= o_n;
            done       <= done_n;
            one_shot_q <= one_shot_n;
`ifdef PATTERN_PULSE_DIR_EN
            dir_q      <= dir_n;
`endif
        end
    end

endmodule

// File: tb/tb_pattern_pulse_generator.sv
// Self-checking bench for pattern_pulse_generator: cycle scoreboard plus directed pattern checks.
module tb_pattern_pulse_generator;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_flag = 1'b0;
    logic [15:0] pattern_in = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        one_shot = 1'b0;
    logic [7:0]  divisor = '0;
    logic        o, busy, done;
    logic [15:0] pattern_q;
`ifdef PATTERN_PULSE_DIR_EN
    logic        dir = 1'b0;
`endif

    int n_compared = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic        o;
        logic        busy;
        logic        done;
        logic [15:0] pat;
    } exp_t;

    exp_t exp_q[$];

    bit          m_run, m_o, m_done, m_os;
    logic [15:0] m_pat;
    int          m_cnt, m_div, m_idx;

    pattern_pulse_generator #(
        .WIDTH(16),
        .DIV_W(8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load_flag (load_flag),
        .pattern_in(pattern_in),
        .start     (start),
        .stop      (stop),
        .one_shot  (one_shot),
        .divisor   (divisor),
`ifdef PATTERN_PULSE_DIR_EN
        .dir       (dir),
`endif
        .o         (o),
        .busy      (busy),
        .done      (done),
        .pattern_q (pattern_q)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour: step index counts emitted bits, cnt counts clocks since the last step.
    task automatic modelStep(input logic rst, input logic ld, input logic [15:0] pin,
                             input logic st, input logic sp, input logic os, input logic [7:0] dv);
        m_done = 1'b0;
        if (rst) begin
            m_run = 0; m_pat = '0; m_o = 0; m_cnt = 0; m_div = 0; m_idx = 0; m_os = 0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1; m_div = int'(dv); m_os = os; m_cnt = 0; m_idx = 0;
            end
            if (ld) m_pat = pin;
        end else if (sp) begin
            m_run = 0;
            m_o   = 0;
            if (ld) m_pat = pin;
        end else if (ld) begin
            m_pat = pin; m_cnt = 0; m_idx = 0;
        end else if (m_cnt < m_div) begin
            m_cnt++;
        end else begin
            m_cnt = 0;
            if (m_idx == 16 && m_os) begin
                m_run = 0; m_o = 0; m_done = 1;
            end else begin
                if (m_idx == 16) m_idx = 0;
                m_o   = m_pat[15];
                m_pat = {m_pat[14:0], m_pat[15]};
                m_idx++;
            end
        end
    endtask

    task automatic compareNext();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = exp_q.pop_front();
            checkOutput("o", 32'(o), 32'(e.o));
            checkOutput("busy", 32'(busy), 32'(e.busy));
            checkOutput("done", 32'(done), 32'(e.done));
            checkOutput("pattern_q", 32'(pattern_q), 32'(e.pat));
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ld, input logic [15:0] pin,
                                 input logic st, input logic sp, input logic os, input logic [7:0] dv);
        exp_t e;
        @(negedge clock);
        reset = rst; load_flag = ld; pattern_in = pin;
        start = st; stop = sp; one_shot = os; divisor = dv;
        modelStep(rst, ld, pin, st, sp, os, dv);
        e.o = m_o; e.busy = m_run; e.done = m_done; e.pat = m_pat;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        compareNext();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        logic [15:0] bits;
        int dones, ones, first_one, last_one, done_at;

        $display("[TB] reset with random inputs");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'($urandom), 16'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), 8'($urandom));
        end
        checkOutput("reset_pattern", 32'(pattern_q), 32'h0);

        $display("[TB] one-shot 16'hA000, divisor 0");
        applyStimulus(1'b0, 1'b1, 16'hA000, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd0);
        bits = '0; dones = 0; done_at = -1;
        for (int i = 0; i < 20; i++) begin
            idleCycle();
            if (i < 16) bits = {bits[14:0], o};
            if (done) begin
                dones++;
                done_at = i;
                checkOutput("oneshot_busy_at_done", 32'(busy), 32'h0);
            end
        end
        checkOutput("oneshot_bits", 32'(bits), 32'hA000);
        checkOutput("oneshot_done_count", 32'(dones), 32'd1);
        checkOutput("oneshot_done_cycle", 32'(done_at), 32'd16);
        checkOutput("oneshot_pattern_restored", 32'(pattern_q), 32'hA000);

        $display("[TB] one-shot 16'hC000, divisor 3");
        applyStimulus(1'b0, 1'b1, 16'hC000, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd3);
        ones = 0; first_one = -1; last_one = -1; dones = 0; done_at = -1;
        for (int i = 0; i < 80; i++) begin
            idleCycle();
            if (o) begin
                ones++;
                if (first_one < 0) first_one = i;
                last_one = i;
            end
            if (done) begin
                dones++;
                done_at = i;
            end
        end
        checkOutput("prescale_first_tick", 32'(first_one), 32'd3);
        checkOutput("prescale_high_clocks", 32'(ones), 32'd8);
        checkOutput("prescale_contiguous", 32'(last_one - first_one), 32'd7);
        checkOutput("prescale_done_count", 32'(dones), 32'd1);
        checkOutput("prescale_done_delay", 32'(done_at - first_one), 32'd64);

        $display("[TB] continuous 16'h8001 with stop");
        applyStimulus(1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0);
        ones = 0; dones = 0;
        for (int i = 0; i < 39; i++) begin
            idleCycle();
            if (i < 32 && o) ones++;
            if (done) dones++;
        end
        checkOutput("continuous_ones_two_passes", 32'(ones), 32'd4);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("stop_o", 32'(o), 32'h0);
        checkOutput("stop_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            if (done) dones++;
        end
        checkOutput("continuous_no_done", 32'(dones), 32'd0);

        $display("[TB] load during run");
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) idleCycle();
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
        checkOutput("load_run_o_holds", 32'(o), 32'h1);
        checkOutput("load_run_busy", 32'(busy), 32'h1);
        idleCycle();
        checkOutput("load_run_o_next_tick", 32'(o), 32'h0);
        for (int i = 0; i < 3; i++) idleCycle();
        checkOutput("load_run_busy_later", 32'(busy), 32'h1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0);

        $display("[TB] reset mid-run");
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 8'd0);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            idleCycle();
            if (done) dones++;
        end
        checkOutput("midrun_o_before_reset", 32'(o), 32'h1);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
        if (done) dones++;
        checkOutput("midrun_reset_o", 32'(o), 32'h0);
        checkOutput("midrun_reset_busy", 32'(busy), 32'h0);
        checkOutput("midrun_reset_pattern", 32'(pattern_q), 32'h0);
        idleCycle();
        if (done) dones++;
        checkOutput("midrun_no_done", 32'(dones), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd0);
        ones = 0; dones = 0;
        for (int i = 0; i < 20; i++) begin
            idleCycle();
            if (o) ones++;
            if (done) dones++;
        end
        checkOutput("zero_pattern_ones", 32'(ones), 32'd0);
        checkOutput("zero_pattern_done", 32'(dones), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
